credit_tx_sender: RTL and testbench
===================================

// Module: credit_tx_sender
// PURPOSE
//  Upstream credit-gated sender feeding the credit FIFO receiver over a point-to-point link.
//  Accepts flits from a local valid/ready source and forwards them on a link with no backpressure.
//  Sends only while it holds credits; each returned credit pulse means one receiver FIFO slot freed.
//  Provides a flush/drain sequence that blocks new traffic until every credit has come home.
// PARAMETERS
//  DATA_WIDTH   32  flit payload width
//  MAX_CREDITS   8  initial/maximum credits; must equal receiver FIFO DEPTH
//  CNT_W        localparam = $clog2(MAX_CREDITS+1), credit counter width
// PORTS
//  clk           in   1           single clock, all logic rising-edge
//  rst           in   1           asynchronous, active-high reset
//  in_valid      in   1           source flit valid
//  in_ready      out  1           sender can accept flit this cycle
//  in_data       in   DATA_WIDTH  source flit payload
//  tx_valid      out  1           link flit valid, one-cycle pulse per flit, no ready
//  tx_data       out  DATA_WIDTH  link flit payload
//  crd_ret       in   1           credit return pulse, one credit per high cycle
//  flush_req     in   1           request drain, sampled in RUN only
//  flush_done    out  1           one-cycle pulse: all credits returned, link idle
//  credit_avail  out  CNT_W       current credit count (registered)
//  crd_err       out  1           sticky: credit returned while counter already at MAX_CREDITS
// BEHAVIOUR
//  Reset (async assert, sync release): tx_valid=0, tx_data=0, credit_avail=MAX_CREDITS, state=RUN,
//   flush_done=0, crd_err=0; in_ready follows combinationally (=1 in RUN with credits).
//  Reset mid-operation: in-flight tx_valid is dropped; credits restored to MAX_CREDITS.
//  in_ready = (state==RUN) && (credit_avail!=0); combinational from registered state, not in_valid.
//  send = in_valid && in_ready. Next cycle: tx_valid=1, tx_data=in_data (latency 1); else tx_valid=0.
//  tx_data holds last value when tx_valid=0.
//  Counter: credit_avail_next = credit_avail - send + ret, where ret = crd_ret && !overflow.
//   Same-cycle send and return: net unchanged; no bypass, so a return at count 0 does not enable a
//   send in that cycle (send possible the following cycle).
//   overflow = crd_ret && credit_avail==MAX_CREDITS && !send: return ignored, crd_err set
//   (sticky until rst). Underflow impossible by construction of in_ready.
//  FSM:
//   RUN   : flush_req=1 -> DRAIN (a send in the same cycle still completes).
//   DRAIN : in_ready=0; credit returns still counted; credit_avail_next==MAX_CREDITS -> DONE.
//           If already MAX_CREDITS on entry, DONE next cycle.
//   DONE  : flush_done=1 for exactly one cycle, in_ready=0; unconditionally -> RUN.
//  flush_req held high across DONE re-triggers DRAIN from RUN (one flush per RUN visit).
// CONFIGURATION
//  CREDIT_TX_PARITY_EN defined: extra port tx_parity (out, 1) = even parity (^) of tx_data,
//   registered alongside tx_data, reset 0.
//  Undefined: port absent, no parity logic; all other behaviour identical.
// TESTING
//  1 Reset, MAX_CREDITS=8, in_valid=1 continuous, no crd_ret -> 8 tx_valid pulses on consecutive
//    cycles, data in order, then in_ready=0 and credit_avail=0.
//  2 At credit_avail=0, pulse crd_ret once -> credit_avail=1 next cycle, one more flit sent, back to 0.
//  3 Steady stream with crd_ret every cycle from credit 4 -> credit_avail stays 4, throughput 1 flit/cycle.
//  4 With 3 flits outstanding, pulse flush_req -> in_ready=0 immediately next cycle; after 3 crd_ret
//    pulses, flush_done pulses one cycle, then RUN with credit_avail=8.
//  5 At credit_avail=8, crd_ret=1 -> crd_err=1 and stays 1; credit_avail remains 8.
//  6 Assert rst mid-stream with tx_valid=1 -> tx_valid=0 at once, credit_avail=8, crd_err=0;
//    with CREDIT_TX_PARITY_EN, tx_data=32'h0000_0007 -> tx_parity=1.

Source files
------------

// File: rtl/credit_tx_sender_if.sv
// rtl/credit_tx_sender_if.sv - source, link, credit and flush signals of the credit-gated sender
// CREDIT_TX_PARITY_EN adds tx_parity to the link side.
interface credit_tx_sender_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_CREDITS = 8
);
  localparam int CNT_W = $clog2(MAX_CREDITS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  crd_ret;
  logic                  flush_req;
  logic                  flush_done;
  logic [CNT_W-1:0]      credit_avail;
  logic                  crd_err;
`ifdef CREDIT_TX_PARITY_EN
  logic                  tx_parity;
`endif

  modport master (
    input  in_valid, in_data, crd_ret, flush_req,
`ifdef CREDIT_TX_PARITY_EN
    output tx_parity,
`endif
    output in_ready, tx_valid, tx_data, flush_done, credit_avail, crd_err
  );

  modport slave (
    output in_valid, in_data, crd_ret, flush_req,
`ifdef CREDIT_TX_PARITY_EN
    input  tx_parity,
`endif
    input  in_ready, tx_valid, tx_data, flush_done, credit_avail, crd_err
  );
endinterface

// File: rtl/credit_tx_sender.sv
// rtl/credit_tx_sender.sv - credit-gated link sender with flush/drain sequence
// CREDIT_TX_PARITY_EN adds a registered even-parity bit alongside tx_data.
module credit_tx_sender #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_CREDITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  credit_tx_sender_if.master bus
);
  localparam int CNT_W = $clog2(MAX_CREDITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CREDITS);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      credit_avail;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  flush_done;
  logic                  crd_err;
  logic                  in_ready;
  logic                  send;
  logic                  overflow;
  logic                  ret;
  logic [CNT_W-1:0]      cnt_next;

  assign in_ready = (state == RUN) && (credit_avail != '0);
  assign send     = bus.in_valid && in_ready;
  // A return at full count is only harmless when a send consumes a credit in the same cycle.
  assign overflow = bus.crd_ret && (credit_avail == MAX_CNT) && !send;
  assign ret      = bus.crd_ret && !overflow;
  assign cnt_next = credit_avail - {{(CNT_W-1){1'b0}}, send} + {{(CNT_W-1){1'b0}}, ret};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      credit_avail <= MAX_CNT;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      flush_done   <= 1'b0;
      crd_err      <= 1'b0;
    end else begin
      tx_valid     <= send;
      credit_avail <= cnt_next;
      flush_done   <= 1'b0;
      if (send) tx_data <= bus.in_data;
      if (overflow) crd_err <= 1'b1;
      case (state)
        RUN:   if (bus.flush_req) state <= DRAIN;
        DRAIN: if (cnt_next == MAX_CNT) begin
                 state      <= DONE;
                 flush_done <= 1'b1;
               end
        DONE:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef CREDIT_TX_PARITY_EN
  logic tx_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_parity <= 1'b0;
    else if (send) tx_parity <= ^bus.in_data;
  end

  assign bus.tx_parity = tx_parity;
`endif

  assign bus.in_ready     = in_ready;
  assign bus.tx_valid     = tx_valid;
  assign bus.tx_data      = tx_data;
  assign bus.flush_done   = flush_done;
  assign bus.credit_avail = credit_avail;
  assign bus.crd_err      = crd_err;
endmodule

// File: tb/tb_credit_tx_sender.sv
// tb/tb_credit_tx_sender.sv - randomized self-checking bench for credit_tx_sender
// Define CREDIT_TX_PARITY_EN to also check tx_parity.
module tb_credit_tx_sender;
  localparam int DW  = 32;
  localparam int MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  credit_tx_sender_if #(.DATA_WIDTH(DW), .MAX_CREDITS(MAX)) bus ();

  credit_tx_sender #(.DATA_WIDTH(DW), .MAX_CREDITS(MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: credits as a plain integer, phase 0=run 1=drain 2=done.
  int          m_credits;
  int          m_phase;
  bit          m_tx_valid;
  bit [DW-1:0] m_tx_data;
  bit          m_flush_done;
  bit          m_err;
  bit [DW-1:0] sb[$];

  function automatic bit m_ready();
    return (m_phase == 0) && (m_credits != 0);
  endfunction

  task automatic model_reset();
    m_credits = MAX; m_phase = 0; m_tx_valid = 0; m_tx_data = '0;
    m_flush_done = 0; m_err = 0; sb.delete();
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.crd_ret = 1'b0; bus.flush_req = 1'b0;
  endtask

  // Advance model by one clock using the inputs currently driven, then sample 1ns after the edge.
  task automatic tick();
    bit snd, ovf;
    int nxt;
    snd = bus.in_valid && m_ready();
    ovf = bus.crd_ret && (m_credits == MAX) && !snd;
    nxt = m_credits - int'(snd) + int'(bus.crd_ret && !ovf);
    m_tx_valid = snd;
    if (snd) begin m_tx_data = bus.in_data; sb.push_back(bus.in_data); end
    if (ovf) m_err = 1;
    m_flush_done = 0;
    case (m_phase)
      0: if (bus.flush_req) m_phase = 1;
      1: if (nxt == MAX) begin m_phase = 2; m_flush_done = 1; end
      default: m_phase = 0;
    endcase
    m_credits = nxt;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %0b exp 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.tx_data !== '0) $display("FAIL reset_tx_data got %h exp 0", bus.tx_data); else n_pass++;
    n_total++; if (bus.credit_avail !== 4'(MAX)) $display("FAIL reset_credit got %0d exp %0d", bus.credit_avail, MAX); else n_pass++;
    n_total++; if (bus.flush_done !== 1'b0) $display("FAIL reset_flush_done got %0b exp 0", bus.flush_done); else n_pass++;
    n_total++; if (bus.crd_err !== 1'b0) $display("FAIL reset_crd_err got %0b exp 0", bus.crd_err); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); else n_pass++;
`ifdef CREDIT_TX_PARITY_EN
    n_total++; if (bus.tx_parity !== 1'b0) $display("FAIL reset_tx_parity got %0b exp 0", bus.tx_parity); else n_pass++;
`endif
  endtask

  // Continuous source, no returns: exactly MAX flits in order, then stalled at zero credits.
  task automatic test_fill();
    bit [DW-1:0] exp_d;
    int          n_seen;
    n_seen = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < MAX + 3; c++) begin
      bus.in_data = $urandom;
      tick();
      if (bus.tx_valid === 1'b1) begin
        n_seen++;
        exp_d = (sb.size() > 0) ? sb.pop_front() : '0;
        n_total++; if (bus.tx_data !== exp_d) $display("FAIL fill_data cyc %0d got %h exp %h", c, bus.tx_data, exp_d); else n_pass++;
      end
      n_total++; if (bus.tx_valid !== m_tx_valid) $display("FAIL fill_tx_valid cyc %0d got %0b exp %0b", c, bus.tx_valid, m_tx_valid); else n_pass++;
    end
    n_total++; if (n_seen != MAX) $display("FAIL fill_count got %0d exp %0d", n_seen, MAX); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL fill_in_ready got %0b exp 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.credit_avail !== 4'd0) $display("FAIL fill_credit got %0d exp 0", bus.credit_avail); else n_pass++;
  endtask

  // From zero credits, one return: no same-cycle bypass, one flit the next cycle, back to zero.
  task automatic test_single_credit();
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    bus.crd_ret  = 1'b1;
    tick();
    bus.crd_ret = 1'b0;
    n_total++; if (bus.credit_avail !== 4'd1) $display("FAIL single_credit_up got %0d exp 1", bus.credit_avail); else n_pass++;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL single_no_bypass got %0b exp 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready got %0b exp 1", bus.in_ready); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.tx_valid !== 1'b1) $display("FAIL single_tx_valid got %0b exp 1", bus.tx_valid); else n_pass++;
    n_total++; if (bus.tx_data !== m_tx_data) $display("FAIL single_tx_data got %h exp %h", bus.tx_data, m_tx_data); else n_pass++;
    n_total++; if (bus.credit_avail !== 4'd0) $display("FAIL single_credit_down got %0d exp 0", bus.credit_avail); else n_pass++;
  endtask

  // Steady stream at credit 4 with a return every cycle holds the count and sustains full rate.
  task automatic test_stream();
    do_reset();
    bus.in_valid = 1'b1;
    repeat (4) begin bus.in_data = $urandom; tick(); end
    bus.crd_ret = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.in_data = $urandom;
      tick();
      n_total++; if (bus.credit_avail !== 4'd4) $display("FAIL stream_credit cyc %0d got %0d exp 4", c, bus.credit_avail); else n_pass++;
      n_total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== m_tx_data)
        $display("FAIL stream_tx cyc %0d got %0b/%h exp 1/%h", c, bus.tx_valid, bus.tx_data, m_tx_data);
      else n_pass++;
    end
    drive_idle();
    tick();
  endtask

  // Three outstanding flits, flush, random returns; bounded wait for flush_done.
  task automatic test_flush();
    int  returned;
    bit  seen;
    do_reset();
    bus.in_valid = 1'b1;
    repeat (3) begin bus.in_data = $urandom; tick(); end
    bus.in_valid  = 1'b0;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_block got %0b exp 0", bus.in_ready); else n_pass++;
    returned = 0;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      bus.crd_ret  = (returned < 3) && ($urandom_range(0, 1) == 1);
      bus.in_valid = $urandom_range(0, 1);
      bus.in_data  = $urandom;
      if (bus.crd_ret) returned++;
      tick();
      n_total++; if (bus.flush_done !== m_flush_done) $display("FAIL flush_done cyc %0d got %0b exp %0b", c, bus.flush_done, m_flush_done); else n_pass++;
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready cyc %0d got %0b exp 0", c, bus.in_ready); else n_pass++;
      n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL flush_tx_valid cyc %0d got %0b exp 0", c, bus.tx_valid); else n_pass++;
      if (bus.flush_done === 1'b1) seen = 1;
    end
    n_total++; if (!seen) $display("FAIL flush_timeout got no flush_done exp pulse"); else n_pass++;
    drive_idle();
    tick();
    n_total++; if (bus.flush_done !== 1'b0) $display("FAIL flush_one_cycle got %0b exp 0", bus.flush_done); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_back_run got %0b exp 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.credit_avail !== 4'(MAX)) $display("FAIL flush_credit got %0d exp %0d", bus.credit_avail, MAX); else n_pass++;
  endtask

  // Mixed random traffic, returns and occasional flushes against the model.
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.crd_ret   = (m_credits < MAX) && ($urandom_range(0, 2) != 0);
      bus.flush_req = ($urandom_range(0, 39) == 0);
      n_total++; if (bus.in_ready !== m_ready()) $display("FAIL rand_in_ready cyc %0d got %0b exp %0b", c, bus.in_ready, m_ready()); else n_pass++;
      tick();
      n_total++; if (bus.tx_valid !== m_tx_valid) $display("FAIL rand_tx_valid cyc %0d got %0b exp %0b", c, bus.tx_valid, m_tx_valid); else n_pass++;
      n_total++; if (bus.tx_data !== m_tx_data) $display("FAIL rand_tx_data cyc %0d got %h exp %h", c, bus.tx_data, m_tx_data); else n_pass++;
      n_total++; if (int'(bus.credit_avail) != m_credits) $display("FAIL rand_credit cyc %0d got %0d exp %0d", c, bus.credit_avail, m_credits); else n_pass++;
      n_total++; if (bus.flush_done !== m_flush_done) $display("FAIL rand_flush_done cyc %0d got %0b exp %0b", c, bus.flush_done, m_flush_done); else n_pass++;
      n_total++; if (bus.crd_err !== m_err) $display("FAIL rand_crd_err cyc %0d got %0b exp %0b", c, bus.crd_err, m_err); else n_pass++;
`ifdef CREDIT_TX_PARITY_EN
      n_total++; if (bus.tx_parity !== ^m_tx_data) $display("FAIL rand_tx_parity cyc %0d got %0b exp %0b", c, bus.tx_parity, ^m_tx_data); else n_pass++;
`endif
    end
    drive_idle();
  endtask

  // Return at full count sets the sticky error and leaves the count at MAX.
  task automatic test_overflow();
    do_reset();
    bus.crd_ret = 1'b1;
    tick();
    bus.crd_ret = 1'b0;
    n_total++; if (bus.crd_err !== 1'b1) $display("FAIL ovf_err_set got %0b exp 1", bus.crd_err); else n_pass++;
    n_total++; if (bus.credit_avail !== 4'(MAX)) $display("FAIL ovf_credit got %0d exp %0d", bus.credit_avail, MAX); else n_pass++;
    repeat (3) tick();
    n_total++; if (bus.crd_err !== 1'b1) $display("FAIL ovf_err_sticky got %0b exp 1", bus.crd_err); else n_pass++;
  endtask

  // Asynchronous reset mid-stream (crd_err still set from the previous test), then parity of 7.
  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    repeat (2) begin bus.in_data = $urandom; tick(); end
    n_total++; if (bus.tx_valid !== 1'b1) $display("FAIL mid_pre_tx_valid got %0b exp 1", bus.tx_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL mid_tx_valid got %0b exp 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.credit_avail !== 4'(MAX)) $display("FAIL mid_credit got %0d exp %0d", bus.credit_avail, MAX); else n_pass++;
    n_total++; if (bus.crd_err !== 1'b0) $display("FAIL mid_crd_err got %0b exp 0", bus.crd_err); else n_pass++;
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0007;
    tick();
    drive_idle();
    n_total++; if (bus.tx_data !== 32'h0000_0007) $display("FAIL mid_tx_data7 got %h exp 00000007", bus.tx_data); else n_pass++;
`ifdef CREDIT_TX_PARITY_EN
    n_total++; if (bus.tx_parity !== 1'b1) $display("FAIL mid_tx_parity got %0b exp 1", bus.tx_parity); else n_pass++;
`endif
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_fill();
    test_single_credit();
    test_stream();
    test_flush();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
